// File: rtl/fpu_div_issuer.sv
// Request side of the single-precision divider stream: issues operand pairs,
// pairs returning quotients with their tags and hands them back in order.
module fpu_div_issuer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic             aclk,
   input  logic             areset,
   // accelerator request port
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   // divider operand channels
   output logic [31:0]      s_axis_a_tdata,
   output logic             s_axis_a_tvalid,
   output logic [31:0]      s_axis_b_tdata,
   output logic             s_axis_b_tvalid,
   // divider result channel
   input  logic [31:0]      m_axis_result_tdata,
   input  logic             m_axis_result_tvalid,
   // accelerator response port
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   // status
   output logic             busy,
   output logic             err_orphan
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } res_entry_t;

   logic [CW-1:0]    credits_q, credits_d;
   logic             iss_valid_q, iss_valid_d;
   logic [31:0]      iss_a_q, iss_a_d;
   logic [31:0]      iss_b_q, iss_b_d;
   logic [AW:0]      tag_wr_q, tag_wr_d;
   logic [AW:0]      tag_rd_q, tag_rd_d;
   logic [AW:0]      res_wr_q, res_wr_d;
   logic [AW:0]      res_rd_q, res_rd_d;
   logic             err_orphan_q, err_orphan_d;

   logic [TAG_W-1:0] tag_mem_q [DEPTH];
   res_entry_t       res_mem_q [DEPTH];

   logic             accept;
   logic             pop;
   logic             tag_empty;
   logic             res_empty;
   logic             tag_pop;
   logic             orphan;
   res_entry_t       res_head;

   // A credit is held from accept until the response leaves, so every issued
   // operation owns a result slot even though the divider cannot be stalled.
   assign req_ready = (credits_q != '0) && !areset;
   assign accept    = req_valid && req_ready;

   assign tag_empty = (tag_wr_q == tag_rd_q);
   assign res_empty = (res_wr_q == res_rd_q);
   assign tag_pop   = m_axis_result_tvalid && !tag_empty;
   assign orphan    = m_axis_result_tvalid && tag_empty;
   assign pop       = !res_empty && rsp_ready;

   assign res_head  = res_mem_q[res_rd_q[AW-1:0]];

   // Next-state for counters, pointers, issue stage and sticky error.
   always_comb begin
      credits_d    = credits_q;
      iss_valid_d  = 1'b0;
      iss_a_d      = iss_a_q;
      iss_b_d      = iss_b_q;
      tag_wr_d     = tag_wr_q;
      tag_rd_d     = tag_rd_q;
      res_wr_d     = res_wr_q;
      res_rd_d     = res_rd_q;
      err_orphan_d = err_orphan_q;

      if (accept && !pop) begin
         credits_d = credits_q - CW'(1);
      end else if (!accept && pop) begin
         credits_d = credits_q + CW'(1);
      end

      if (accept) begin
         iss_valid_d = 1'b1;
         iss_a_d     = req_a;
         iss_b_d     = req_b;
         tag_wr_d    = tag_wr_q + (AW+1)'(1);
      end

      if (tag_pop) begin
         tag_rd_d = tag_rd_q + (AW+1)'(1);
         res_wr_d = res_wr_q + (AW+1)'(1);
      end

      if (pop) begin
         res_rd_d = res_rd_q + (AW+1)'(1);
      end

      if (orphan) begin
         err_orphan_d = 1'b1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         credits_q    <= CW'(DEPTH);
         iss_valid_q  <= 1'b0;
         iss_a_q      <= '0;
         iss_b_q      <= '0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
         res_wr_q     <= '0;
         res_rd_q     <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         credits_q    <= credits_d;
         iss_valid_q  <= iss_valid_d;
         iss_a_q      <= iss_a_d;
         iss_b_q      <= iss_b_d;
         tag_wr_q     <= tag_wr_d;
         tag_rd_q     <= tag_rd_d;
         res_wr_q     <= res_wr_d;
         res_rd_q     <= res_rd_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   // Storage arrays carry no reset; validity comes from the pointers alone.
   always_ff @(posedge aclk) begin
      if (accept) begin
         tag_mem_q[tag_wr_q[AW-1:0]] <= req_tag;
      end
      if (tag_pop) begin
         res_mem_q[res_wr_q[AW-1:0]] <= '{tag:  tag_mem_q[tag_rd_q[AW-1:0]],
                                          data: m_axis_result_tdata};
      end
   end

   assign s_axis_a_tdata  = iss_a_q;
   assign s_axis_b_tdata  = iss_b_q;
   assign s_axis_a_tvalid = iss_valid_q;
   assign s_axis_b_tvalid = iss_valid_q;

   assign rsp_valid  = !res_empty;
   assign rsp_data   = res_head.data;
   assign rsp_tag    = res_head.tag;

   assign busy       = (credits_q != CW'(DEPTH));
   assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_fpu_div_issuer.sv
// Bench for fpu_div_issuer: fixed-latency divider model, directed and random
// traffic, and a cycle monitor checking issue, credit and response behaviour.
module tb_fpu_div_issuer;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned LAT   = 4;

   logic             aclk = 1'b0;
   logic             areset;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [TAG_W-1:0] req_tag;
   logic [31:0]      s_axis_a_tdata;
   logic             s_axis_a_tvalid;
   logic [31:0]      s_axis_b_tdata;
   logic             s_axis_b_tvalid;
   logic [31:0]      m_axis_result_tdata;
   logic             m_axis_result_tvalid;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;
   logic             err_orphan;

   logic             orph_valid;
   logic [31:0]      orph_data;
   logic             div_valid = 1'b0;
   logic [31:0]      div_data  = '0;
   logic [LAT-1:0]   pv        = '0;
   logic [31:0]      pd [LAT];

   int               checks = 0;
   int               errors = 0;

   // reference model state
   int               cnt, outst, buffered, nresp, nacc;
   int unsigned      cur_q;
   logic [TAG_W+31:0] exp_q [$];
   logic             exp_iss_v, stall_prev;
   logic [31:0]      exp_a, exp_b, last_a, last_b, hold_data;
   logic [TAG_W-1:0] hold_tag;

   fpu_div_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .aclk                 (aclk),
      .areset               (areset),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_a                (req_a),
      .req_b                (req_b),
      .req_tag              (req_tag),
      .s_axis_a_tdata       (s_axis_a_tdata),
      .s_axis_a_tvalid      (s_axis_a_tvalid),
      .s_axis_b_tdata       (s_axis_b_tdata),
      .s_axis_b_tvalid      (s_axis_b_tvalid),
      .m_axis_result_tdata  (m_axis_result_tdata),
      .m_axis_result_tvalid (m_axis_result_tvalid),
      .rsp_valid            (rsp_valid),
      .rsp_ready            (rsp_ready),
      .rsp_data             (rsp_data),
      .rsp_tag              (rsp_tag),
      .busy                 (busy),
      .err_orphan           (err_orphan)
   );

   always #5 aclk = ~aclk;

   assign m_axis_result_tvalid = div_valid | orph_valid;
   assign m_axis_result_tdata  = orph_valid ? orph_data : div_data;

   // Positive integer <-> IEEE single (exact for values below 2^24).
   function automatic logic [31:0] int2fp(input int unsigned n);
      int unsigned e;
      logic [31:0] sh;
      e = 0;
      for (int i = 0; i < 24; i++) if (n[i]) e = i;
      sh = 32'(n << (23 - e));
      return {1'b0, 8'(127 + e), sh[22:0]};
   endfunction

   function automatic int unsigned fp2int(input logic [31:0] f);
      int unsigned e;
      e = 32'(f[30:23]) - 127;
      return {8'd0, 1'b1, f[22:0]} >> (23 - e);
   endfunction

   function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
      int unsigned bi;
      bi = fp2int(b);
      return (bi == 0) ? 32'h0 : int2fp(fp2int(a) / bi);
   endfunction

   // Divider: fixed pipeline, keeps running across the issuer's reset.
   always @(negedge aclk) begin
      for (int i = LAT - 1; i > 0; i--) pd[i] = pd[i-1];
      pv        = {pv[LAT-2:0], s_axis_a_tvalid};
      pd[0]     = div_model(s_axis_a_tdata, s_axis_b_tdata);
      div_valid = pv[LAT-1];
      div_data  = pd[LAT-1];
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_model();
      cnt = 0; outst = 0; buffered = 0;
      exp_q.delete();
      exp_iss_v = 1'b0; stall_prev = 1'b0;
      last_a = '0; last_b = '0;
   endtask

   task automatic set_req(input logic [TAG_W-1:0] t);
      int unsigned q, b;
      q = $urandom_range(1, 1000);
      b = $urandom_range(1, 1000);
      req_a = int2fp(q * b); req_b = int2fp(b); req_tag = t;
      cur_q = q; req_valid = 1'b1;
   endtask

   task automatic send(input logic [TAG_W-1:0] t);
      bit done;
      done = 0;
      set_req(t);
      for (int n = 0; n < 100 && !done; n++) begin
         done = req_ready;
         tick();
      end
      req_valid = 1'b0;
      chk("send_accept", 64'(done), 64'(1));
   endtask

   task automatic wait_rsp();
      for (int n = 0; n < 50 && !rsp_valid; n++) tick();
      chk("rsp_arrives", 64'(rsp_valid), 64'(1));
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      for (int n = 0; n < 300 && busy; n++) tick();
      rsp_ready = 1'b0;
      chk("drain_idle", 64'(busy), 64'(0));
   endtask

   // Cycle monitor: result accounting at posedge, output checks at negedge.
   task automatic monitor();
      logic [TAG_W+31:0] e;
      forever begin
         @(aclk);
         if (aclk === 1'b1) begin
            if (!areset && m_axis_result_tvalid && outst > 0) begin
               chk("no_push_into_full", 64'(buffered < int'(DEPTH)), 64'(1));
               outst--; buffered++;
            end
         end else if (!areset) begin
            chk("issue_valid", 64'(s_axis_a_tvalid), 64'(exp_iss_v));
            chk("valid_pair", 64'(s_axis_b_tvalid), 64'(s_axis_a_tvalid));
            if (exp_iss_v) begin
               last_a = exp_a; last_b = exp_b;
            end
            chk("tdata_a", 64'(s_axis_a_tdata), 64'(last_a));
            chk("tdata_b", 64'(s_axis_b_tdata), 64'(last_b));
            chk("req_ready", 64'(req_ready), 64'(cnt < int'(DEPTH)));
            chk("busy", 64'(busy), 64'(cnt != 0));
            chk("rsp_valid", 64'(rsp_valid), 64'(buffered != 0));
            if (stall_prev && rsp_valid) begin
               chk("stall_data", 64'(rsp_data), 64'(hold_data));
               chk("stall_tag", 64'(rsp_tag), 64'(hold_tag));
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("rsp_tag", 64'(rsp_tag), 64'(e[TAG_W+31:32]));
                  chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
               end else begin
                  chk("rsp_expected", 64'(0), 64'(1));
               end
               nresp++; cnt--; buffered--;
            end
            exp_iss_v = req_valid && req_ready;
            if (exp_iss_v) begin
               exp_q.push_back({req_tag, int2fp(cur_q)});
               exp_a = req_a; exp_b = req_b;
               cnt++; outst++; nacc++;
            end
            stall_prev = rsp_valid && !rsp_ready;
            hold_data  = rsp_data;
            hold_tag   = rsp_tag;
         end
      end
   endtask

   initial begin
      int nxt, r0, issued, g;
      bit acc;
      areset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_tag = '0; cur_q = 1;
      orph_valid = 1'b0; orph_data = '0;
      nresp = 0; nacc = 0;
      clear_model();
      fork monitor(); join_none
      tick(); tick();
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_tvalid", 64'({s_axis_a_tvalid, s_axis_b_tvalid}), 64'(0));
      chk("rst_tdata", {s_axis_a_tdata, s_axis_b_tdata}, 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err_orphan", 64'(err_orphan), 64'(0));
      areset = 1'b0;
      tick();

      // single divide: 6.0 / 2.0
      req_a = 32'h40C0_0000; req_b = 32'h4000_0000; req_tag = 4'd3;
      cur_q = 3; req_valid = 1'b1;
      chk("t1_ready", 64'(req_ready), 64'(1));
      tick();
      req_valid = 1'b0;
      wait_rsp();
      chk("t1_data", 64'(rsp_data), 64'h4040_0000);
      chk("t1_tag", 64'(rsp_tag), 64'(3));
      chk("t1_busy", 64'(busy), 64'(1));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t1_busy_after", 64'(busy), 64'(0));
      chk("t1_rsp_after", 64'(rsp_valid), 64'(0));

      // credit exhaustion
      nxt = 0; r0 = nresp;
      set_req(TAG_W'(0));
      for (int c = 0; c < 10; c++) begin
         acc = req_valid && req_ready;
         tick();
         if (acc) begin
            nxt++;
            if (nxt < 10) set_req(TAG_W'(nxt));
         end
      end
      chk("t2_accepted", 64'(nxt), 64'(DEPTH));
      chk("t2_ready_low", 64'(req_ready), 64'(0));
      for (int c = 0; c < 10; c++) tick();
      rsp_ready = 1'b1;
      g = 0;
      while (!(nxt == 10 && nresp == r0 + 10) && g < 300) begin
         acc = req_valid && req_ready;
         tick();
         g++;
         if (acc) begin
            nxt++;
            if (nxt < 10) set_req(TAG_W'(nxt)); else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("t2_total_accepted", 64'(nxt), 64'(10));
      chk("t2_total_rsp", 64'(nresp - r0), 64'(10));
      drain();

      // simultaneous accept and pop at one credit
      for (int k = 0; k < 7; k++) send(TAG_W'(k));
      for (int c = 0; c < 12; c++) tick();
      chk("t3_pending", 64'(rsp_valid), 64'(1));
      set_req(TAG_W'(12));
      rsp_ready = 1'b1;
      chk("t3_ready_before", 64'(req_ready), 64'(1));
      tick();
      req_valid = 1'b0; rsp_ready = 1'b0;
      chk("t3_ready_after_both", 64'(req_ready), 64'(1));
      set_req(TAG_W'(13));
      tick();
      req_valid = 1'b0;
      chk("t3_credits_zero", 64'(req_ready), 64'(0));
      rsp_ready = 1'b1;
      chk("t3_no_same_cycle", 64'(req_ready), 64'(0));
      tick();
      rsp_ready = 1'b0;
      chk("t3_ready_next", 64'(req_ready), 64'(1));
      drain();

      // random traffic with random backpressure
      r0 = nresp; issued = 0;
      for (int k = 0; k < 5000 && !(issued == 100 && nresp == r0 + 100); k++) begin
         rsp_ready = 1'($urandom_range(0, 1));
         if (!req_valid && issued < 100 && $urandom_range(0, 3) != 0)
            set_req(TAG_W'($urandom_range(0, 15)));
         acc = req_valid && req_ready;
         tick();
         if (acc) begin
            issued++;
            req_valid = 1'b0;
         end
      end
      rsp_ready = 1'b0;
      chk("t4_issued", 64'(issued), 64'(100));
      chk("t4_responses", 64'(nresp - r0), 64'(100));
      drain();

      // orphan result
      for (int c = 0; c < int'(LAT) + 4; c++) tick();
      orph_data = 32'h3F80_0000; orph_valid = 1'b1;
      tick();
      orph_valid = 1'b0;
      chk("t5_err", 64'(err_orphan), 64'(1));
      chk("t5_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("t5_busy", 64'(busy), 64'(0));
      for (int c = 0; c < 3; c++) tick();
      chk("t5_sticky", 64'(err_orphan), 64'(1));
      chk("t5_ready", 64'(req_ready), 64'(1));

      // reset with 2 buffered and 4 in flight
      send(TAG_W'(1)); send(TAG_W'(2));
      for (int c = 0; c < 12; c++) tick();
      for (int k = 0; k < 4; k++) begin
         set_req(TAG_W'(k + 4));
         tick();
      end
      req_valid = 1'b0;
      tick();
      areset = 1'b1;
      clear_model();
      #1;
      chk("t6_req_ready", 64'(req_ready), 64'(0));
      chk("t6_tvalid", 64'({s_axis_a_tvalid, s_axis_b_tvalid}), 64'(0));
      chk("t6_tdata", {s_axis_a_tdata, s_axis_b_tdata}, 64'(0));
      chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("t6_busy", 64'(busy), 64'(0));
      chk("t6_err_cleared", 64'(err_orphan), 64'(0));
      #1;
      areset = 1'b0;
      for (int c = 0; c < 12; c++) tick();
      chk("t6_late_orphan", 64'(err_orphan), 64'(1));
      chk("t6_rsp_idle", 64'(rsp_valid), 64'(0));
      chk("t6_busy_idle", 64'(busy), 64'(0));
      send(TAG_W'(9));
      wait_rsp();
      chk("t6_new_tag", 64'(rsp_tag), 64'(9));
      chk("t6_new_data", 64'(rsp_data), 64'(int2fp(cur_q)));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
